// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential fetch, EX-stage redirects (branch/JAL/JALR),
// and a one-deep pending redirect that is held until the instruction cache accepts it.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            icache_stall,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            is_zero,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush,
  output logic            misalign,
  output logic            redirect_pending
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;

  logic              redirect_evt;
  logic [XLEN-1:0]   raw_target;
  logic [XLEN-1:0]   target;
  logic              unused_bits;

  // Redirect decode and target selection; JALR has priority over JAL and branch.
  always_comb begin
    redirect_evt = ex_valid & ~ex_stall & (ex_jal | ex_jalr | (ex_branch & is_zero));
    if (ex_jalr) begin
      raw_target = {alu_result[XLEN-1:1], 1'b0};
    end else begin
      raw_target = ex_pc + ex_imm;
    end
    target = {raw_target[XLEN-1:2], 2'b00};
  end

  assign unused_bits      = ^{alu_result[0], raw_target[0]};
  assign pc               = pc_q;
  assign pc_plus4         = pc_q + 32'd4;
  assign flush            = redirect_evt & ~rst;
  assign misalign         = redirect_evt & raw_target[1] & ~rst;
  assign redirect_pending = (state_q == PEND);

  // Next-state logic: a new event always wins over a previously latched redirect.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      RUN: begin
        if (icache_stall) begin
          if (redirect_evt) begin
            pend_pc_d = target;
            state_d   = PEND;
          end else begin
            pend_pc_d = pend_pc_q;
          end
        end else begin
          if (redirect_evt) begin
            pc_d = target;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      PEND: begin
        if (icache_stall) begin
          if (redirect_evt) begin
            pend_pc_d = target;
          end else begin
            pend_pc_d = pend_pc_q;
          end
        end else begin
          if (redirect_evt) begin
            pc_d = target;
          end else begin
            pc_d = pend_pc_q;
          end
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The parameter list SHALL be: RESET_PC, 32'h0000_0000, fetch address loaded by reset.
REQ-002 The parameter list SHALL be: XLEN, 32, datapath width (ALU_BITS); no other value is supported.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; these ports SHALL be the first two entries below.
REQ-004 clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 icache_stall  in  1  fetch cannot accept a new address; pc SHALL hold.
REQ-007 ex_valid  in  1  EX stage holds a live (unsquashed) instruction.
REQ-008 ex_stall  in  1  EX instruction is not retiring this cycle.
REQ-009 ex_branch  in  1  EX instruction is a conditional branch.
REQ-010 ex_jal  in  1  EX instruction is JAL.
REQ-011 ex_jalr  in  1  EX instruction is JALR.
REQ-012 is_zero  in  1  ALU branch-condition output; 1 = branch taken.
REQ-013 alu_result  in  32  ALU result; JALR target (rs1+imm).
REQ-014 ex_pc  in  32  PC of the EX instruction.
REQ-015 ex_imm  in  32  sign-extended branch/JAL offset.
REQ-016 pc  out  32  current fetch address to instruction cache.
REQ-017 pc_plus4  out  32  pc + 4, combinational.
REQ-018 flush  out  1  squash IF/ID and ID/EX this cycle.
REQ-019 misalign  out  1  redirect target had bit[1] set (one-cycle pulse).
REQ-020 redirect_pending  out  1  a redirect is latched, waiting for fetch to accept it.

Function
REQ-021 A redirect event SHALL occur exactly when ex_valid=1, ex_stall=0 and (ex_jal | ex_jalr | (ex_branch & is_zero)).
REQ-022 The target SHALL be ex_pc+ex_imm for branch/JAL and {alu_result[31:1],1'b0} for JALR, with the sum taken modulo 2^32.
REQ-023 Priority on simultaneous decode bits SHALL be jalr > jal > branch.
REQ-024 In a redirect event cycle, flush SHALL be 1 combinationally.
REQ-025 misalign SHALL be 1 in the event cycle if target[1]=1; the redirect SHALL still be taken, with target[1:0] forced to 00.
REQ-026 The FSM SHALL have states RUN and PEND.
REQ-027 RUN, event, icache_stall=0: pc <= target next edge; state remains RUN.
REQ-028 RUN, event, icache_stall=1: target latched in pend_pc; state goes to PEND; pc holds.
REQ-029 RUN, no event: pc <= pc+4 if icache_stall=0, else pc holds.
REQ-030 PEND, icache_stall=1: pc holds; pend_pc holds unless a new event occurs, which SHALL overwrite pend_pc and pulse flush again.
REQ-031 PEND, icache_stall=0: pc <= pend_pc (or the new target if an event occurs the same cycle); state goes to RUN.
REQ-032 redirect_pending SHALL equal (state==PEND).
REQ-033 pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-034 Latency SHALL be one clock from a non-stalled redirect event to pc showing the target.
REQ-035 The events counted for a stalled EX instruction (ex_stall=1) SHALL be zero: no flush, no pc change from it.

Reset
REQ-036 While rst=1: pc=RESET_PC, state=RUN, pend_pc=0, flush=0, misalign=0, redirect_pending=0; rst overrides all other inputs, including a mid-PEND redirect, which is discarded.
REQ-037 First edge after rst deasserts with icache_stall=0: pc <= RESET_PC+4.

Verification
REQ-038 Sequential fetch: reset, icache_stall=0 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC.
REQ-039 Taken branch: ex_pc=0x100, ex_imm=0xFFFF_FFF0, ex_branch=1, is_zero=1 -> flush=1 that cycle; pc=0xF0 next cycle.
REQ-040 Branch, not taken, is_zero=0 -> flush=0; pc advances +4.
REQ-041 JALR, alu_result=0x203, icache_stall=1 for 2 cycles -> redirect_pending=1 for 2 cycles, misalign=1 in the event cycle; pc=0x200 one cycle after the stall drops.
REQ-042 Held EX: ex_jal=1, ex_stall=1 for 3 cycles -> no flush, then exactly one flush when ex_stall=0.
REQ-043 rst asserted while in PEND -> next cycle pc=RESET_PC, redirect_pending=0.
